// File: rtl/sudoku_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sudoku_pkg : shared types, loader states and ASCII constants             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sudoku_pkg;

   localparam int GRID_DIM = 9;
   localparam int CELLS    = 81;

   typedef logic [3:0] cell_t;
   typedef logic [3:0] idx_t;

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_TRIG = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [7:0] CHAR_ZERO  = 8'h30;
   localparam logic [7:0] CHAR_ONE   = 8'h31;
   localparam logic [7:0] CHAR_NINE  = 8'h39;
   localparam logic [7:0] EMPTY_CHAR = 8'h2E;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_TAB   = 8'h09;
   localparam logic [7:0] CHAR_COMMA = 8'h2C;
   localparam logic [7:0] CHAR_BAR   = 8'h7C;

endpackage
`default_nettype wire

// File: rtl/sudoku_char_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sudoku_char_decode : classifies one ASCII byte as cell, layout or bad    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sudoku_char_decode
   import sudoku_pkg::*;
#(
   parameter logic [7:0] EMPTY_CHAR = sudoku_pkg::EMPTY_CHAR
)(
   input  logic [7:0] in_byte,
   output logic       is_cell,
   output logic       is_sep,
   output logic       is_bad,
   output cell_t      value
);

   always_comb begin
      is_cell = 1'b0;
      is_sep  = 1'b0;
      value   = '0;
      if (in_byte >= CHAR_ONE && in_byte <= CHAR_NINE) begin
         is_cell = 1'b1;
         value   = in_byte[3:0];
      end else if (in_byte == CHAR_ZERO || in_byte == EMPTY_CHAR) begin
         is_cell = 1'b1;
      end else begin
         case (in_byte)
            CHAR_SPACE, CHAR_CR, CHAR_LF,
            CHAR_TAB, CHAR_COMMA, CHAR_BAR: is_sep = 1'b1;
            default:                        is_sep = 1'b0;
         endcase
      end
   end

   assign is_bad = !is_cell && !is_sep;

endmodule
`default_nettype wire

// File: rtl/sudoku_grid_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sudoku_grid_loader : ASCII stream to 9x9 cell writes, then awaits check  |
// | Option: SUDOKU_LOADER_AUTOCHECK_EN enables the automatic trigger state   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sudoku_grid_loader
   import sudoku_pkg::*;
#(
   parameter int         CELLS      = 81,
   parameter logic [7:0] EMPTY_CHAR = sudoku_pkg::EMPTY_CHAR
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       cell_we,
   output logic [3:0] cell_row,
   output logic [3:0] cell_col,
   output logic [3:0] cell_val,
   output logic       check_trigger,
   input  logic       check_done,
   input  logic       check_err,
   output logic       grid_full,
   output logic       result_valid,
   output logic       result_err,
   output logic       char_err,
   input  logic       restart
);

   localparam logic [6:0] c_last_cell = 7'(CELLS - 1);
   localparam idx_t       c_last_idx  = idx_t'(GRID_DIM - 1);

   logic [1:0] r_state;
   idx_t       r_row;
   idx_t       r_col;
   logic [6:0] r_count;
   logic       r_filled;
   logic       r_armed;
   logic       r_cell_we;
   idx_t       r_cell_row;
   idx_t       r_cell_col;
   cell_t      r_cell_val;
   logic       r_grid_full;
   logic       r_result_valid;
   logic       r_result_err;
   logic       r_char_err;

   logic       w_is_cell;
   logic       w_is_sep;
   logic       w_is_bad;
   cell_t      w_value;
   logic       w_accept;

   sudoku_char_decode #(
      .EMPTY_CHAR (EMPTY_CHAR)
   ) u_decode (
      .in_byte (in_data),
      .is_cell (w_is_cell),
      .is_sep  (w_is_sep),
      .is_bad  (w_is_bad),
      .value   (w_value)
   );

   // r_filled closes the input as soon as the last cell byte is taken,
   // so nothing slips in during the final strobe cycle.
   assign in_ready = (r_state == ST_LOAD) && !r_filled && !restart;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= ST_LOAD;
         r_row          <= '0;
         r_col          <= '0;
         r_count        <= '0;
         r_filled       <= 1'b0;
         r_armed        <= 1'b0;
         r_cell_we      <= 1'b0;
         r_cell_row     <= '0;
         r_cell_col     <= '0;
         r_cell_val     <= '0;
         r_grid_full    <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_err   <= 1'b0;
         r_char_err     <= 1'b0;
      end else if (restart) begin
         r_state        <= ST_LOAD;
         r_row          <= '0;
         r_col          <= '0;
         r_count        <= '0;
         r_filled       <= 1'b0;
         r_armed        <= 1'b0;
         r_cell_we      <= 1'b0;
         r_grid_full    <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_err   <= 1'b0;
         r_char_err     <= 1'b0;
      end else begin
         r_cell_we <= 1'b0;
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  case ({w_is_cell, w_is_sep, w_is_bad})
                     3'b100: begin
                        r_cell_we  <= 1'b1;
                        r_cell_row <= r_row;
                        r_cell_col <= r_col;
                        r_cell_val <= w_value;
                        if (r_col == c_last_idx) begin
                           r_col <= '0;
                           r_row <= r_row + 1'b1;
                        end else begin
                           r_col <= r_col + 1'b1;
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == c_last_cell) r_filled <= 1'b1;
                     end
                     3'b010:  begin end
                     default: r_char_err <= 1'b1;
                  endcase
               end
               if (r_filled) begin
                  r_grid_full <= 1'b1;
                  r_armed     <= 1'b0;
`ifdef SUDOKU_LOADER_AUTOCHECK_EN
                  r_state     <= ST_TRIG;
`else
                  r_state     <= ST_WAIT;
`endif
               end
            end
`ifdef SUDOKU_LOADER_AUTOCHECK_EN
            ST_TRIG: r_state <= ST_WAIT;
`endif
            ST_WAIT: begin
               // First WAIT cycle only arms, so a done level left over from
               // the previous run is never taken as this grid's result.
               if (!r_armed) begin
                  r_armed <= 1'b1;
               end else if (check_done) begin
                  r_result_valid <= 1'b1;
                  r_result_err   <= check_err;
                  r_state        <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_DONE;
            default: r_state <= ST_LOAD;
         endcase
      end
   end

`ifdef SUDOKU_LOADER_AUTOCHECK_EN
   assign check_trigger = (r_state == ST_TRIG);
`else
   assign check_trigger = 1'b0;
`endif

   assign cell_we      = r_cell_we;
   assign cell_row     = r_cell_row;
   assign cell_col     = r_cell_col;
   assign cell_val     = r_cell_val;
   assign grid_full    = r_grid_full;
   assign result_valid = r_result_valid;
   assign result_err   = r_result_err;
   assign char_err     = r_char_err;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_grid_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sudoku_grid_loader : self-checking bench for sudoku_grid_loader       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sudoku_grid_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       cell_we;
   logic [3:0] cell_row;
   logic [3:0] cell_col;
   logic [3:0] cell_val;
   logic       check_trigger;
   logic       check_done = 1'b0;
   logic       check_err = 1'b0;
   logic       grid_full;
   logic       result_valid;
   logic       result_err;
   logic       char_err;
   logic       restart = 1'b0;

   sudoku_grid_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .cell_we       (cell_we),
      .cell_row      (cell_row),
      .cell_col      (cell_col),
      .cell_val      (cell_val),
      .check_trigger (check_trigger),
      .check_done    (check_done),
      .check_err     (check_err),
      .grid_full     (grid_full),
      .result_valid  (result_valid),
      .result_err    (result_err),
      .char_err      (char_err),
      .restart       (restart)
   );

   always #5 clk = ~clk;

`ifdef SUDOKU_LOADER_AUTOCHECK_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [11:0] exp_q[$];
   logic [11:0] strobe_log [0:127];
   int          strobe_cnt = 0;
   int          trig_cnt = 0;
   int          m_cells = 0;
   bit          m_char_err = 1'b0;
   string       grid_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected stream: the n-th cell byte lands at row n/9, col n%9.
   task automatic model_byte(input logic [7:0] b);
      if (b >= "1" && b <= "9" || b == "0" || b == ".") begin
         exp_q.push_back({4'(m_cells / 9), 4'(m_cells % 9), (b == ".") ? 4'd0 : 4'(b - "0")});
         m_cells++;
      end else if (!(b == " " || b == 8'h0D || b == 8'h0A || b == 8'h09 || b == "," || b == "|")) begin
         m_char_err = 1'b1;
      end
   endtask

   task automatic model_clear();
      m_cells    = 0;
      m_char_err = 1'b0;
      exp_q.delete();
      strobe_cnt = 0;
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         int budget;
         bit taken;
         budget = 0;
         taken  = 1'b0;
         while (!taken) begin
            @(negedge clk);
            in_data  = s[i];
            in_valid = 1'b1;
            if (in_ready) begin
               @(posedge clk);
               model_byte(s[i]);
               taken = 1'b1;
            end else begin
               budget++;
               if (budget > 20) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL send_timeout: byte %0d not accepted, in_ready=%0b expected 1", i, in_ready);
                  taken = 1'b1;
               end
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_restart(input bit with_done);
      @(negedge clk);
      restart    = 1'b1;
      in_valid   = 1'b1;
      in_data    = "6";
      check_done = with_done;
      check_err  = with_done;
      #1;
      check("restart_in_ready", in_ready, 1'b0);
      @(posedge clk);
      model_clear();
      @(negedge clk);
      restart    = 1'b0;
      in_valid   = 1'b0;
      check_done = 1'b0;
      check_err  = 1'b0;
      #1;
      check("restart_grid_full", grid_full, 1'b0);
      check("restart_result_valid", result_valid, 1'b0);
      check("restart_result_err", result_err, 1'b0);
      check("restart_char_err", char_err, 1'b0);
      check("restart_in_ready_after", in_ready, 1'b1);
   endtask

   always @(negedge clk) begin : cmp
      logic [11:0] e;
      if (rst_n) begin
         if (cell_we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_strobe: got r%0d c%0d v%0d expected no strobe", cell_row, cell_col, cell_val);
            end else begin
               e = exp_q.pop_front();
               check("strobe", {cell_row, cell_col, cell_val}, e);
            end
            if (strobe_cnt < 128) strobe_log[strobe_cnt] = {cell_row, cell_col, cell_val};
            strobe_cnt++;
         end
         check("char_err", char_err, m_char_err);
         if (check_trigger) trig_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      grid_b = {"534678912\r\n672195348\r\n198342567\r\n859761423\r\n426853791\r\n",
                "713924856\r\n961537284\r\n287419635\r\n345286179"};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_outputs", {cell_we, check_trigger, grid_full, result_valid, result_err, char_err}, 6'b0);
      check("rst_cell_bus", {cell_row, cell_col, cell_val}, 12'h000);

      // Partial first row with empties and a line feed
      send("53..7....\n");
      @(negedge clk);
      check("t1_count", strobe_cnt, 9);
      check("t1_s0", strobe_log[0], 12'h005);
      check("t1_s1", strobe_log[1], 12'h013);
      check("t1_s2", strobe_log[2], 12'h020);
      check("t1_s4", strobe_log[4], 12'h047);
      check("t1_char_err", char_err, 1'b0);

      // Illegal byte inside row 3
      send("123456789\n456789123\n78X9123456\n1234");
      @(negedge clk);
      check("t3_char_err", char_err, 1'b1);
      check("t3_after_x", strobe_log[29], 12'h329);
      check("t3_count", strobe_cnt, 40);

      // Restart after 40 cells with a byte offered in the same cycle
      do_restart(1'b0);

      // Full grid; a stale done/err level is left high from a previous run
      check_done = 1'b1;
      check_err  = 1'b1;
      send(grid_b);
      check("t2_in_ready_last", in_ready, 1'b0);
      @(negedge clk);
      check("t2_grid_full", grid_full, 1'b1);
      check("t2_trigger", check_trigger, AUTO);
      check("t2_in_ready_full", in_ready, 1'b0);
      check("t2_count", strobe_cnt, 81);
      check("t2_first", strobe_log[0], 12'h005);
      check("t2_last", strobe_log[80], 12'h889);
      if (AUTO) @(negedge clk);
      @(negedge clk);
      check("t4_stale_ignored", result_valid, 1'b0);
      check_done = 1'b0;
      @(negedge clk);
      check("t4_low1", result_valid, 1'b0);
      @(negedge clk);
      check("t4_low2", result_valid, 1'b0);
      check_done = 1'b1;
      check_err  = 1'b0;
      @(negedge clk);
      check("t4_result_valid", result_valid, 1'b1);
      check("t4_result_err", result_err, 1'b0);
      check_done = 1'b0;

      // DONE stalls further bytes and holds its outputs
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = "5";
      #1;
      check("done_in_ready", in_ready, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("done_hold", {grid_full, result_valid, result_err}, 3'b110);

      // Second full grid; checker reports an error
      do_restart(1'b0);
      send(grid_b);
      repeat (4) @(negedge clk);
      check("t6_wait", result_valid, 1'b0);
      check_done = 1'b1;
      check_err  = 1'b1;
      @(negedge clk);
      check("t6_result_valid", result_valid, 1'b1);
      check("t6_result_err", result_err, 1'b1);
      check_done = 1'b0;
      check_err  = 1'b0;

      // Restart and done in the same cycle: the result must not latch
      do_restart(1'b0);
      send(grid_b);
      repeat (4) @(negedge clk);
      do_restart(1'b1);

      // Reset while a byte is being accepted
      send("12");
      @(negedge clk);
      in_data  = "3";
      in_valid = 1'b1;
      rst_n    = 1'b0;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_drop_strobe", cell_we, 1'b0);
      check("rst_mid_flags", {grid_full, char_err, result_valid}, 3'b000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_in_ready", in_ready, 1'b1);
      send("9");
      @(negedge clk);
      check("rst_mid_count", strobe_cnt, 1);
      check("rst_mid_first", strobe_log[0], 12'h009);

      check("trigger_pulses", trig_cnt, AUTO ? 3 : 0);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
